lbp_scan_ctrl: RTL and testbench



---
 rtl/lbp_scan_ctrl_if.sv | 30 +++
 rtl/lbp_scan_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lbp_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/lbp_scan_ctrl_if.sv
// Bundle between the LBP scan controller, the gray-image memory, the 3x3 window and the result memory.
// Latency: none, wires only.
// Backpressure: none; gray_ready is a level that only starts a frame.
interface lbp_scan_ctrl_if #(
  parameter int AW = 14
) ();
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic          initialize;
  logic          right;
  logic          down;
  logic          left;
  logic [3:0]    cycle;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic          finish;

  modport master (
    input  gray_ready,
    output gray_req, gray_addr, initialize, right, down, left, cycle,
    output lbp_valid, lbp_addr, finish
  );

  modport slave (
    output gray_ready,
    input  gray_req, gray_addr, initialize, right, down, left, cycle,
    input  lbp_valid, lbp_addr, finish
  );
endinterface

// File: rtl/lbp_scan_ctrl.sv
// Serpentine scan controller: gray fetch addresses, window shift strobes and LBP result writes.
// Latency: first result 11 cycles after gray_ready is seen, then one result every 5 cycles.
// Backpressure: none; gray_ready only starts a frame, finish holds until reset.
module lbp_scan_ctrl #(
  parameter int W  = 128,
  parameter int AW = 14
) (
  input logic             clk,
  input logic             reset,
  lbp_scan_ctrl_if.master bus
);

  // Row and column each take half of the address; address = {row, col}.
  localparam int RW = AW / 2;
  localparam logic [RW-1:0] LAST = RW'(W - 2);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] MV_RIGHT = 2'd0;
  localparam logic [1:0] MV_LEFT  = 2'd1;
  localparam logic [1:0] MV_DOWN  = 2'd2;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] col_q, col_d;
  logic [1:0]    mv_q, mv_d;
  logic [1:0]    mv_nx;

  logic          gray_req_q, gray_req_d;
  logic [AW-1:0] gray_addr_q, gray_addr_d;
  logic          lbp_valid_q, lbp_valid_d;
  logic [AW-1:0] lbp_addr_q, lbp_addr_d;
  logic          finish_q, finish_d;
  logic          initialize_q, right_q, down_q, left_q;
  logic [3:0]    cycle_q;

  function automatic logic [AW-1:0] pix(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return {r, c};
  endfunction

  // Initial 3x3 fetch idx 0..8 walks rows 0..2, cols 0..2 of the top-left corner.
  function automatic logic [AW-1:0] init_addr(input logic [3:0] idx);
    logic [RW-1:0] r;
    logic [RW-1:0] c;
    if (idx >= 4'd6) begin
      r = RW'(2);
      c = RW'(idx - 4'd6);
    end else if (idx >= 4'd3) begin
      r = RW'(1);
      c = RW'(idx - 4'd3);
    end else begin
      r = RW'(0);
      c = RW'(idx);
    end
    return pix(r, c);
  endfunction

  // Fetch j of a move, relative to the centre the window holds before the move.
  function automatic logic [AW-1:0] move_addr(input logic [1:0] mv, input logic [1:0] j,
                                              input logic [RW-1:0] r, input logic [RW-1:0] c);
    logic [RW-1:0] fr;
    logic [RW-1:0] fc;
    fr = r - RW'(1) + RW'(j);
    fc = c + RW'(2);
    case (mv)
      MV_LEFT: fc = c - RW'(2);
      MV_DOWN: begin
        fr = r + RW'(2);
        fc = c - RW'(1) + RW'(j);
      end
      default: ;
    endcase
    return pix(fr, fc);
  endfunction

  // Odd rows run rightwards, even rows leftwards; a row end turns down.
  assign mv_nx = row_q[0] ? ((col_q == LAST)   ? MV_DOWN : MV_RIGHT)
                          : ((col_q == RW'(1)) ? MV_DOWN : MV_LEFT);

  // Next state plus the registered fetch/write outputs for the cycle it represents.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    row_d       = row_q;
    col_d       = col_q;
    mv_d        = mv_q;
    gray_req_d  = 1'b0;
    gray_addr_d = gray_addr_q;
    lbp_valid_d = 1'b0;
    lbp_addr_d  = lbp_addr_q;
    finish_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.gray_ready) begin
          state_d     = S_INIT;
          cnt_d       = 4'd0;
          row_d       = RW'(1);
          col_d       = RW'(1);
          gray_req_d  = 1'b1;
          gray_addr_d = init_addr(4'd0);
        end
      end
      S_INIT: begin
        if (cnt_q == 4'd8) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d       = cnt_q + 4'd1;
          gray_req_d  = 1'b1;
          gray_addr_d = init_addr(cnt_q + 4'd1);
        end
      end
      S_MOVE: begin
        if (cnt_q == 4'd2) begin
          state_d = S_DRAIN;
          case (mv_q)
            MV_RIGHT: col_d = col_q + RW'(1);
            MV_LEFT:  col_d = col_q - RW'(1);
            default:  row_d = row_q + RW'(1);
          endcase
        end else begin
          cnt_d       = cnt_q + 4'd1;
          gray_req_d  = 1'b1;
          gray_addr_d = move_addr(mv_q, cnt_q[1:0] + 2'd1, row_q, col_q);
        end
      end
      S_DRAIN: begin
        state_d     = S_WRITE;
        lbp_valid_d = 1'b1;
        lbp_addr_d  = pix(row_q, col_q);
      end
      S_WRITE: begin
        if (row_q == LAST && col_q == RW'(1)) begin
          state_d     = S_DONE;
          finish_d    = 1'b1;
          gray_addr_d = '0;
          lbp_addr_d  = '0;
        end else begin
          state_d     = S_MOVE;
          cnt_d       = 4'd0;
          mv_d        = mv_nx;
          gray_req_d  = 1'b1;
          gray_addr_d = move_addr(mv_nx, 2'd0, row_q, col_q);
        end
      end
      S_DONE: begin
        finish_d    = 1'b1;
        gray_addr_d = '0;
        lbp_addr_d  = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, scan position and fetch/write output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      row_q       <= '0;
      col_q       <= '0;
      mv_q        <= MV_RIGHT;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mv_q        <= mv_d;
      gray_req_q  <= gray_req_d;
      gray_addr_q <= gray_addr_d;
      lbp_valid_q <= lbp_valid_d;
      lbp_addr_q  <= lbp_addr_d;
      finish_q    <= finish_d;
    end
  end

  // Strobes trail the fetch by one cycle, so they decode the current fetch state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      initialize_q <= 1'b0;
      right_q      <= 1'b0;
      down_q       <= 1'b0;
      left_q       <= 1'b0;
      cycle_q      <= 4'd0;
    end else begin
      initialize_q <= (state_q == S_INIT);
      right_q      <= (state_q == S_MOVE) && (mv_q == MV_RIGHT);
      down_q       <= (state_q == S_MOVE) && (mv_q == MV_DOWN);
      left_q       <= (state_q == S_MOVE) && (mv_q == MV_LEFT);
      cycle_q      <= (state_q == S_MOVE) ? (cnt_q + 4'd1) : 4'd0;
    end
  end

  assign bus.gray_req   = gray_req_q;
  assign bus.gray_addr  = gray_addr_q;
  assign bus.initialize = initialize_q;
  assign bus.right      = right_q;
  assign bus.down       = down_q;
  assign bus.left       = left_q;
  assign bus.cycle      = cycle_q;
  assign bus.lbp_valid  = lbp_valid_q;
  assign bus.lbp_addr   = lbp_addr_q;
  assign bus.finish     = finish_q;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Bench for lbp_scan_ctrl: scoreboard of fetches, strobes and writes for a full 128x128 frame.
// Latency: expectations carry the cycle number relative to the gray_ready sampling edge.
// Backpressure: none; covers idle hold, async reset mid-move and frame restart.
module tb_lbp_scan_ctrl;

  localparam int W  = 128;
  localparam int AW = 14;
  localparam int NPIX = (W - 2) * (W - 2);
  localparam int LAST_CYC = 11 + 5 * (NPIX - 1);

  logic clk;
  logic reset;

  lbp_scan_ctrl_if #(.AW(AW)) bus ();

  lbp_scan_ctrl #(.W(W), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tcnt = 0;
  int base = 0;
  bit mon_en = 1'b0;

  // Each entry: [63:32] cycle relative to frame start, [31:0] payload.
  logic [63:0] fq[$];
  logic [63:0] sq[$];
  logic [63:0] wq[$];

  int          m_rel;
  int          m_n;
  int          m_typ;
  int          nwr;
  int          last_wr;
  logic [63:0] m_exp;

  logic [38:0] outs;
  assign outs = {bus.gray_req, bus.gray_addr, bus.initialize, bus.right, bus.down, bus.left,
                 bus.cycle, bus.lbp_valid, bus.lbp_addr, bus.finish};

  always @(posedge clk) tcnt <= tcnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Serpentine walk of centres; each new centre brings in the three pixels on its leading edge.
  task automatic build_frame();
    int n, k, pr, pc, cc, typ, a;
    fq.delete();
    sq.delete();
    wq.delete();
    for (int i = 0; i < 9; i++) begin
      fq.push_back({32'(i + 1), 32'((i / 3) * W + (i % 3))});
      sq.push_back({32'(i + 2), 32'(16)});
    end
    wq.push_back({32'd11, 32'(W + 1)});
    n = 0;
    pr = 1;
    pc = 1;
    for (int rr = 1; rr <= W - 2; rr++) begin
      for (int j = 0; j < W - 2; j++) begin
        cc = (rr % 2 == 1) ? (1 + j) : (W - 2 - j);
        if (!(rr == 1 && j == 0)) begin
          n++;
          k = 11 + 5 * (n - 1);
          for (int m = 0; m < 3; m++) begin
            if (rr == pr + 1) begin
              typ = 3;
              a = (rr + 1) * W + cc - 1 + m;
            end else if (cc == pc + 1) begin
              typ = 2;
              a = (rr - 1 + m) * W + cc + 1;
            end else begin
              typ = 4;
              a = (rr - 1 + m) * W + cc - 1;
            end
            fq.push_back({32'(k + 1 + m), 32'(a)});
            sq.push_back({32'(k + 2 + m), 32'(typ * 16 + m + 1)});
          end
          wq.push_back({32'(k + 5), 32'(rr * W + cc)});
          pr = rr;
          pc = cc;
        end
      end
    end
  endtask

  // Scoreboard: pop and compare whenever the DUT shows a fetch, strobe or write.
  always @(negedge clk) begin
    if (mon_en) begin
      m_rel = tcnt - base;
      if (bus.gray_req) begin
        m_exp = (fq.size() != 0) ? fq.pop_front() : '1;
        chk("fetch", {32'(m_rel), 32'(bus.gray_addr)}, m_exp);
      end
      m_n = int'(bus.initialize) + int'(bus.right) + int'(bus.down) + int'(bus.left);
      if (m_n != 0) begin
        chk("onehot", 64'(m_n), 64'd1);
        m_typ = bus.initialize ? 1 : bus.right ? 2 : bus.down ? 3 : 4;
        m_exp = (sq.size() != 0) ? sq.pop_front() : '1;
        chk("strobe", {32'(m_rel), 32'(m_typ * 16 + int'(bus.cycle))}, m_exp);
      end else begin
        chk("cyc_idle", 64'(bus.cycle), 64'd0);
      end
      if (bus.lbp_valid) begin
        nwr++;
        last_wr = int'(bus.lbp_addr);
        m_exp = (wq.size() != 0) ? wq.pop_front() : '1;
        chk("write", {32'(m_rel), 32'(bus.lbp_addr)}, m_exp);
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    #2;
    build_frame();
    nwr = 0;
    last_wr = 0;
    base = tcnt;
    bus.gray_ready = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    int fin_rel;
    reset = 1'b1;
    bus.gray_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 64'(outs), 64'd0);
    #2;
    reset = 1'b0;

    repeat (20) begin
      @(negedge clk);
      chk("idle_quiet", 64'({bus.gray_req, bus.initialize, bus.right, bus.down, bus.left,
                             bus.lbp_valid, bus.finish}), 64'd0);
    end

    // Partial frame, then reset in the middle of the second pixel's move.
    start_frame();
    repeat (13) @(negedge clk);
    #2;
    reset = 1'b1;
    bus.gray_ready = 1'b0;
    mon_en = 1'b0;
    #1;
    chk("rst_async", 64'(outs), 64'd0);
    chk("rst_writes", 64'(nwr), 64'd1);
    repeat (2) @(negedge clk);
    chk("rst_hold", 64'(outs), 64'd0);
    #2;
    reset = 1'b0;

    // Full frame from a clean restart.
    start_frame();
    fin_rel = -1;
    for (int t = 0; t < LAST_CYC + 100; t++) begin
      @(negedge clk);
      if (bus.finish) begin
        fin_rel = tcnt - base;
        break;
      end
    end
    chk("finish_cyc", 64'(fin_rel), 64'(LAST_CYC + 1));
    chk("n_writes", 64'(nwr), 64'(NPIX));
    chk("last_addr", 64'(last_wr), 64'((W - 2) * W + 1));
    chk("fq_left", 64'(fq.size()), 64'd0);
    chk("sq_left", 64'(sq.size()), 64'd0);
    chk("wq_left", 64'(wq.size()), 64'd0);
    repeat (5) begin
      @(negedge clk);
      chk("done_hold", 64'(outs), 64'd1);
    end
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
